// File: rtl/memread_unit_pkg.sv
// memread_unit_pkg: load encodings, bus size codes, FSM states and decode helpers
package memread_unit_pkg;
   localparam logic [2:0] LD_OFF   = 3'b000;
   localparam logic [2:0] LD_WORD  = 3'b001;
   localparam logic [2:0] LD_HALF  = 3'b010;
   localparam logic [2:0] LD_HALFU = 3'b011;
   localparam logic [2:0] LD_BYTE  = 3'b100;
   localparam logic [2:0] LD_BYTEU = 3'b101;
   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_DROP} state_t;
   function automatic logic is_load(input logic [2:0] t);
      return t != LD_OFF && t <= LD_BYTEU;
   endfunction
   function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
      return (t == LD_WORD && a != 2'b00) || ((t == LD_HALF || t == LD_HALFU) && a[0]);
   endfunction
   function automatic logic [1:0] size_of(input logic [2:0] t);
      return t == LD_WORD ? SZ_WORD : (t == LD_HALF || t == LD_HALFU) ? SZ_HALF : SZ_BYTE;
   endfunction
endpackage

// File: rtl/memread_unit_load_extend.sv
// load_extend: picks the addressed byte/half of the returned word and extends it
module load_extend
   import memread_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       ltype_i,
   input  logic [1:0]       off_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic [WIDTH-1:0] result_o
);
   logic [15:0] h;
   always_comb begin
      h = 16'(rdata_i >> {off_i, 3'b000});
      result_o = ltype_i == LD_BYTE  ? {{(WIDTH-8){h[7]}}, h[7:0]} :
                 ltype_i == LD_BYTEU ? {{(WIDTH-8){1'b0}}, h[7:0]} :
                 ltype_i == LD_HALF  ? {{(WIDTH-16){h[15]}}, h} :
                 ltype_i == LD_HALFU ? {{(WIDTH-16){1'b0}}, h} : rdata_i;
   end
endmodule

// File: rtl/memread_unit.sv
// memread_unit: MEM-stage load engine; one sram-like read per load, stalls until data returns
module memread_unit
   import memread_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       load_type,
   input  logic [WIDTH-1:0] addr,
   input  logic             pipe_stall,
   input  logic             flush,
   output logic             data_req,
   output logic             data_wr,
   output logic [1:0]       data_size,
   output logic [WIDTH-1:0] data_addr,
   input  logic             data_addr_ok,
   input  logic             data_data_ok,
   input  logic [WIDTH-1:0] data_rdata,
   output logic [WIDTH-1:0] load_result,
   output logic             load_done,
   output logic             stall_req,
   output logic             adel,
   output logic [WIDTH-1:0] badvaddr
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d, result_q, result_d, ext;
   logic [1:0]       size_q, size_d;
   logic [2:0]       type_q, type_d;
   logic             bad_addr, start;

   load_extend #(.WIDTH(WIDTH)) u_ext (
      .ltype_i (type_q),
      .off_i   (addr_q[1:0]),
      .rdata_i (data_rdata),
      .result_o(ext)
   );

   assign bad_addr    = is_load(load_type) && misaligned(load_type, addr[1:0]);
   assign start       = is_load(load_type) && !bad_addr && !flush;
   assign data_wr     = 1'b0;
   assign data_size   = size_q;
   assign data_addr   = addr_q;
   assign load_result = result_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      type_d    = type_q;
      result_d  = result_q;
      data_req  = 1'b0;
      load_done = 1'b0;
      stall_req = 1'b0;
      adel      = 1'b0;
      badvaddr  = '0;
      unique case (state_q)
         S_IDLE: begin
            adel     = bad_addr;
            badvaddr = bad_addr ? addr : '0;
            if (start) begin
               state_d   = S_ADDR;
               addr_d    = addr;
               size_d    = size_of(load_type);
               type_d    = load_type;
               stall_req = 1'b1;
            end
         end
         S_ADDR: begin
            data_req  = 1'b1;
            stall_req = 1'b1;
            if (data_addr_ok && data_data_ok) begin
               state_d  = S_DONE;
               result_d = ext;
            end else if (data_addr_ok) state_d = flush ? S_DROP : S_DATA;
            else if (flush) state_d = S_IDLE;
         end
         S_DATA: begin
            stall_req = 1'b1;
            if (data_data_ok) begin
               state_d  = S_DONE;
               result_d = ext;
            end else if (flush) state_d = S_DROP;
         end
         // an accepted request always returns data; swallow it so it cannot complete a later load
         S_DROP: begin
            stall_req = 1'b1;
            if (data_data_ok) state_d = S_IDLE;
         end
         S_DONE: begin
            load_done = 1'b1;
            if (!pipe_stall || flush) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         type_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         type_q   <= type_d;
         result_q <= result_d;
      end
   end
endmodule

// File: tb/tb_memread_unit.sv
// tb_memread_unit: scoreboarded scenarios for the load engine
module tb_memread_unit;
   import memread_unit_pkg::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic [2:0]  load_type = '0;
   logic [31:0] addr = '0, data_rdata = '0;
   logic        pipe_stall = 1'b0, flush = 1'b0, data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic        data_req, data_wr, load_done, stall_req, adel;
   logic [1:0]  data_size;
   logic [31:0] data_addr, load_result, badvaddr;
   int          checks = 0, errors = 0;
   logic [31:0] exp_q[$];

   memread_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .load_type(load_type), .addr(addr), .pipe_stall(pipe_stall),
      .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata), .load_result(load_result), .load_done(load_done),
      .stall_req(stall_req), .adel(adel), .badvaddr(badvaddr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({data_req, data_wr, data_size, data_addr, load_result, load_done, stall_req, adel, badvaddr} !== '0) begin
         errors++;
         $display("FAIL reset: outputs not zero req=%b size=%0d addr=%h res=%h done=%b stall=%b adel=%b",
                  data_req, data_size, data_addr, load_result, load_done, stall_req, adel);
      end
      tick;
      tick;
      rst = 1'b0;
      tick;
   endtask

   // issue a load, data_ok comes dlat cycles after the addr_ok cycle; returns in DONE
   task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] expv, input logic [1:0] exp_sz, input int dlat);
      int done_k = -1;
      bit stall_bad = 0;
      logic [31:0] e;
      load_type = t;
      addr = a;
      #1;
      checks++;
      if (stall_req !== 1'b1 || adel !== 1'b0) begin
         errors++;
         $display("FAIL start: stall=%b adel=%b want 1/0", stall_req, adel);
      end
      exp_q.push_back(expv);
      tick;
      load_type = LD_OFF;
      addr = $urandom;
      checks++;
      if ({data_req, data_size, data_addr} !== {1'b1, exp_sz, a}) begin
         errors++;
         $display("FAIL request: req=%b size=%0d addr=%h want 1 %0d %h", data_req, data_size, data_addr, exp_sz, a);
      end
      for (int k = 0; k < 40; k++) begin
         data_addr_ok = (k == 0);
         data_data_ok = (k == dlat);
         data_rdata   = (k == dlat) ? rd : $urandom;
         #1;
         if (load_done) begin
            done_k = k;
            break;
         end
         if (stall_req !== 1'b1) stall_bad = 1;
         tick;
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      checks++;
      if (done_k != dlat + 1) begin
         errors++;
         $display("FAIL latency: done at %0d want %0d", done_k, dlat + 1);
      end
      checks++;
      if (stall_bad || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL stall: held=%0d done_stall=%b want 1/0", !stall_bad, stall_req);
      end
      e = exp_q.pop_front();
      checks++;
      if (load_result !== e) begin
         errors++;
         $display("FAIL result: got %h want %h", load_result, e);
      end
   endtask

   task automatic finish_done;
      pipe_stall = 1'b0;
      tick;
      checks++;
      if (load_done !== 1'b0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL idle: done=%b stall=%b want 0/0", load_done, stall_req);
      end
   endtask

   task automatic test_extract;
      run_load(LD_BYTE,  32'h1003, 32'h80FF1234, 32'hFFFFFF80, SZ_BYTE, 1); finish_done;
      run_load(LD_BYTEU, 32'h1003, 32'h80FF1234, 32'h00000080, SZ_BYTE, 1); finish_done;
      run_load(LD_HALF,  32'h1002, 32'h80011234, 32'hFFFF8001, SZ_HALF, 1); finish_done;
      run_load(LD_HALFU, 32'h1002, 32'h80011234, 32'h00008001, SZ_HALF, 1); finish_done;
      run_load(LD_WORD,  32'h1000, 32'h80011234, 32'h80011234, SZ_WORD, 1); finish_done;
      run_load(LD_BYTE,  32'h1001, 32'h80FF1234, 32'h00000012, SZ_BYTE, 2); finish_done;
      run_load(LD_BYTEU, 32'h1002, 32'h80FF1234, 32'h000000FF, SZ_BYTE, 1); finish_done;
      run_load(LD_HALF,  32'h1000, 32'h0000F00F, 32'hFFFFF00F, SZ_HALF, 1); finish_done;
      run_load(LD_HALFU, 32'h1000, 32'h0000F00F, 32'h0000F00F, SZ_HALF, 1); finish_done;
   endtask

   task automatic adel_case(input logic [2:0] t, input logic [31:0] a);
      load_type = t;
      addr = a;
      #1;
      checks++;
      if ({adel, badvaddr, data_req, stall_req} !== {1'b1, a, 2'b00}) begin
         errors++;
         $display("FAIL adel: adel=%b bad=%h req=%b stall=%b want 1 %h 0 0", adel, badvaddr, data_req, stall_req, a);
      end
      tick;
      checks++;
      if (data_req !== 1'b0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL adel_noreq: req=%b stall=%b want 0/0", data_req, stall_req);
      end
      load_type = LD_OFF;
      tick;
   endtask

   task automatic test_adel;
      adel_case(LD_WORD,  32'h1001);
      adel_case(LD_HALF,  32'h1003);
      adel_case(LD_HALFU, 32'h1001);
   endtask

   task automatic test_fast;
      run_load(LD_WORD, 32'h2004, 32'h0BADBEEF, 32'h0BADBEEF, SZ_WORD, 0);
      finish_done;
   endtask

   task automatic test_slow;
      run_load(LD_HALFU, 32'h2006, 32'hBEEF0000, 32'h0000BEEF, SZ_HALF, 5);
      finish_done;
   endtask

   task automatic test_flush_data;
      bit seen_done = 0;
      load_type = LD_WORD;
      addr = 32'h4000;
      tick;
      load_type = LD_OFF;
      for (int k = 0; k < 7; k++) begin
         data_addr_ok = (k == 0);
         flush        = (k == 1);
         data_data_ok = (k == 3);
         data_rdata   = 32'h12345678;
         #1;
         if (load_done) seen_done = 1;
         if (k == 2 || k == 3) begin
            checks++;
            if (stall_req !== 1'b1 || data_req !== 1'b0) begin
               errors++;
               $display("FAIL drop_hold k=%0d: stall=%b req=%b want 1/0", k, stall_req, data_req);
            end
         end
         if (k == 4) begin
            checks++;
            if (stall_req !== 1'b0) begin
               errors++;
               $display("FAIL drop_exit: stall=%b want 0", stall_req);
            end
         end
         tick;
      end
      {data_addr_ok, data_data_ok, flush} = '0;
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL drop_done: load_done seen 1 want 0");
      end
   endtask

   task automatic test_flush_addr;
      load_type = LD_WORD;
      addr = 32'h5000;
      tick;
      load_type = LD_OFF;
      flush = 1'b1;
      #1;
      checks++;
      if (data_req !== 1'b1) begin
         errors++;
         $display("FAIL flush_addr_req: req=%b want 1", data_req);
      end
      tick;
      flush = 1'b0;
      #1;
      checks++;
      if (data_req !== 1'b0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_addr_drop: req=%b stall=%b want 0/0", data_req, stall_req);
      end
   endtask

   task automatic test_pipe_stall;
      pipe_stall = 1'b1;
      run_load(LD_WORD, 32'h3000, 32'hCAFEF00D, 32'hCAFEF00D, SZ_WORD, 1);
      for (int i = 0; i < 2; i++) begin
         data_rdata = $urandom;
         tick;
         checks++;
         if (load_done !== 1'b1 || load_result !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL hold: done=%b res=%h want 1 cafef00d", load_done, load_result);
         end
      end
      finish_done;
   endtask

   task automatic test_rst_mid;
      load_type = LD_HALF;
      addr = 32'h6002;
      tick;
      load_type = LD_OFF;
      data_addr_ok = 1'b1;
      tick;
      data_addr_ok = 1'b0;
      checks++;
      if (stall_req !== 1'b1 || data_addr !== 32'h6002) begin
         errors++;
         $display("FAIL rst_pre: stall=%b addr=%h want 1 6002", stall_req, data_addr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({data_req, data_wr, data_size, data_addr, load_result, load_done, stall_req, adel, badvaddr} !== '0) begin
         errors++;
         $display("FAIL rst_mid: req=%b size=%0d addr=%h res=%h done=%b stall=%b",
                  data_req, data_size, data_addr, load_result, load_done, stall_req);
      end
      #2;
      rst = 1'b0;
      tick;
      data_data_ok = 1'b1;
      data_rdata = 32'hAAAA5555;
      tick;
      data_data_ok = 1'b0;
      #1;
      checks++;
      if (load_done !== 1'b0 || load_result !== 32'h0 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL stale: done=%b res=%h stall=%b want 0 0 0", load_done, load_result, stall_req);
      end
   endtask

   initial begin
      test_reset;
      test_extract;
      test_adel;
      test_fast;
      test_slow;
      test_flush_data;
      test_flush_addr;
      test_pipe_stall;
      test_rst_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
